// File: rtl/rvfi_retire_queue_pkg.sv
// Shared RVFI retirement record types for the trace path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: XLEN default, rvfi_rec_t record layout, RVFI_REC_W record width.
package rvfi_retire_queue_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_wmask;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
  } rvfi_rec_t;

  localparam int RVFI_REC_W = $bits(rvfi_rec_t);

endpackage

// File: rtl/rvfi_retire_queue_if.sv
// Retire-record input bundle and NRET-wide flattened RVFI output bundle.
// Latency: n/a (wiring only).
// Backpressure: in_ready toward the writeback stage, out_ready from the trace consumer.
// Modports: slave = queue side, master = producer/consumer (testbench or core) side.
interface rvfi_retire_queue_if #(
  parameter int XLEN    = rvfi_retire_queue_pkg::XLEN,
  parameter int DEPTH   = 8,
  parameter int NRET    = 2,
  parameter int ORDER_W = 64
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         in_insn;
  logic [XLEN-1:0]         in_pc_rdata;
  logic [XLEN-1:0]         in_pc_wdata;
  logic [4:0]              in_rs1_addr;
  logic [4:0]              in_rs2_addr;
  logic [XLEN-1:0]         in_rs1_rdata;
  logic [XLEN-1:0]         in_rs2_rdata;
  logic [4:0]              in_rd_addr;
  logic [XLEN-1:0]         in_rd_wdata;
  logic [XLEN-1:0]         in_mem_addr;
  logic [3:0]              in_mem_wmask;
  logic [XLEN-1:0]         in_mem_rdata;
  logic [XLEN-1:0]         in_mem_wdata;

  logic                    out_ready;
  logic [NRET-1:0]         out_valid;
  logic [NRET*ORDER_W-1:0] out_order;
  logic [NRET*XLEN-1:0]    out_insn;
  logic [NRET*XLEN-1:0]    out_pc_rdata;
  logic [NRET*XLEN-1:0]    out_pc_wdata;
  logic [NRET*5-1:0]       out_rs1_addr;
  logic [NRET*5-1:0]       out_rs2_addr;
  logic [NRET*XLEN-1:0]    out_rs1_rdata;
  logic [NRET*XLEN-1:0]    out_rs2_rdata;
  logic [NRET*5-1:0]       out_rd_addr;
  logic [NRET*XLEN-1:0]    out_rd_wdata;
  logic [NRET*XLEN-1:0]    out_mem_addr;
  logic [NRET*4-1:0]       out_mem_wmask;
  logic [NRET*XLEN-1:0]    out_mem_rdata;
  logic [NRET*XLEN-1:0]    out_mem_wdata;
  logic                    overflow;
  logic [CW-1:0]           count;

  modport slave (
    input  in_valid, in_insn, in_pc_rdata, in_pc_wdata, in_rs1_addr, in_rs2_addr,
           in_rs1_rdata, in_rs2_rdata, in_rd_addr, in_rd_wdata, in_mem_addr,
           in_mem_wmask, in_mem_rdata, in_mem_wdata, out_ready,
    output in_ready, out_valid, out_order, out_insn, out_pc_rdata, out_pc_wdata,
           out_rs1_addr, out_rs2_addr, out_rs1_rdata, out_rs2_rdata, out_rd_addr,
           out_rd_wdata, out_mem_addr, out_mem_wmask, out_mem_rdata, out_mem_wdata,
           overflow, count
  );

  modport master (
    output in_valid, in_insn, in_pc_rdata, in_pc_wdata, in_rs1_addr, in_rs2_addr,
           in_rs1_rdata, in_rs2_rdata, in_rd_addr, in_rd_wdata, in_mem_addr,
           in_mem_wmask, in_mem_rdata, in_mem_wdata, out_ready,
    input  in_ready, out_valid, out_order, out_insn, out_pc_rdata, out_pc_wdata,
           out_rs1_addr, out_rs2_addr, out_rs1_rdata, out_rs2_rdata, out_rd_addr,
           out_rd_wdata, out_mem_addr, out_mem_wmask, out_mem_rdata, out_mem_wdata,
           overflow, count
  );

endinterface

// File: rtl/rvfi_retire_queue_mpop_fifo.sv
// Generic single-push / NRET-pop FIFO; channel i shows entry (head+i) mod DEPTH.
// Latency: a push at edge k is readable from cycle k+1; reads are combinational.
// Backpressure: caller must only push when count < DEPTH; pop retires min(count, NRET).
// Ports: clk, rst (sync active-low), push/push_dat, pop, rd_dat/rd_vld per channel, count.
module rvfi_retire_queue_mpop_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int NRET  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_dat,
  input  logic                        pop,
  output logic [NRET-1:0][WIDTH-1:0]  rd_dat,
  output logic [NRET-1:0]             rd_vld,
  output logic [$clog2(DEPTH):0]      count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    n_pop;
  logic [AW-1:0]    idx;

  always_comb begin
    n_pop = '0;
    if (pop) n_pop = (count_q > CW'(NRET)) ? CW'(NRET) : count_q;
  end

  // Power-of-two DEPTH: pointer arithmetic wraps for free, including
  // multi-entry reads straddling the end of storage.
  always_comb begin
    idx    = '0;
    rd_dat = '0;
    rd_vld = '0;
    for (int i = 0; i < NRET; i++) begin
      idx       = head + AW'(i);
      rd_dat[i] = mem[idx];
      rd_vld[i] = (count_q > CW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      // Truncation keeps head mod DEPTH even when NRET == DEPTH.
      head    <= head + n_pop[AW-1:0];
      count_q <= count_q + CW'(push) - n_pop;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (rst && push) mem[tail] <= push_dat;
  end

  assign count = count_q;

endmodule

// File: rtl/rvfi_retire_queue.sv
// Retirement trace queue: stamps order, applies the x0 rule, presents NRET RVFI channels.
// Latency: record accepted at edge k visible on a channel from cycle k+1.
// Backpressure: in_ready = count < DEPTH (no pop bypass); refused records set sticky overflow.
// Ports: clk, rst (sync active-low), bus (rvfi_retire_queue_if.slave).
module rvfi_retire_queue #(
  parameter int XLEN    = rvfi_retire_queue_pkg::XLEN,
  parameter int DEPTH   = 8,
  parameter int NRET    = 2,
  parameter int ORDER_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  rvfi_retire_queue_if.slave   bus
);
  import rvfi_retire_queue_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    rvfi_rec_t          rec;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [ORDER_W-1:0]         order_q;
  logic                       overflow_q;
  logic                       push;
  rvfi_rec_t                  in_rec;
  logic [NRET-1:0][EW-1:0]    rd_dat;
  logic [NRET-1:0]            rd_vld;
  logic [CW-1:0]              fifo_count;
  entry_t                     e;

  assign bus.in_ready = (fifo_count < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign bus.count    = fifo_count;
  assign bus.overflow = overflow_q;

  always_comb begin
    in_rec.insn      = bus.in_insn;
    in_rec.pc_rdata  = bus.in_pc_rdata;
    in_rec.pc_wdata  = bus.in_pc_wdata;
    in_rec.rs1_addr  = bus.in_rs1_addr;
    in_rec.rs2_addr  = bus.in_rs2_addr;
    in_rec.rs1_rdata = bus.in_rs1_rdata;
    in_rec.rs2_rdata = bus.in_rs2_rdata;
    in_rec.rd_addr   = bus.in_rd_addr;
    // Writes to x0 are architecturally invisible, so the trace reports 0.
    in_rec.rd_wdata  = (bus.in_rd_addr == 5'd0) ? '0 : bus.in_rd_wdata;
    in_rec.mem_addr  = bus.in_mem_addr;
    in_rec.mem_wmask = bus.in_mem_wmask;
    in_rec.mem_rdata = bus.in_mem_rdata;
    in_rec.mem_wdata = bus.in_mem_wdata;
  end

  rvfi_retire_queue_mpop_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .NRET  (NRET)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({order_q, in_rec}),
    .pop      (bus.out_ready),
    .rd_dat   (rd_dat),
    .rd_vld   (rd_vld),
    .count    (fifo_count)
  );

  // Dropped records do not consume an order number.
  always_ff @(posedge clk) begin
    if (!rst) begin
      order_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) order_q <= order_q + ORDER_W'(1);
      if (bus.in_valid && !bus.in_ready) overflow_q <= 1'b1;
    end
  end

  // Invalid channels are zero-gated so stale storage never leaks onto the trace.
  always_comb begin
    e                 = '0;
    bus.out_valid     = rd_vld;
    bus.out_order     = '0;
    bus.out_insn      = '0;
    bus.out_pc_rdata  = '0;
    bus.out_pc_wdata  = '0;
    bus.out_rs1_addr  = '0;
    bus.out_rs2_addr  = '0;
    bus.out_rs1_rdata = '0;
    bus.out_rs2_rdata = '0;
    bus.out_rd_addr   = '0;
    bus.out_rd_wdata  = '0;
    bus.out_mem_addr  = '0;
    bus.out_mem_wmask = '0;
    bus.out_mem_rdata = '0;
    bus.out_mem_wdata = '0;
    for (int i = 0; i < NRET; i++) begin
      e = rd_vld[i] ? entry_t'(rd_dat[i]) : '0;
      bus.out_order[i*ORDER_W +: ORDER_W] = e.order;
      bus.out_insn[i*XLEN +: XLEN]        = e.rec.insn;
      bus.out_pc_rdata[i*XLEN +: XLEN]    = e.rec.pc_rdata;
      bus.out_pc_wdata[i*XLEN +: XLEN]    = e.rec.pc_wdata;
      bus.out_rs1_addr[i*5 +: 5]          = e.rec.rs1_addr;
      bus.out_rs2_addr[i*5 +: 5]          = e.rec.rs2_addr;
      bus.out_rs1_rdata[i*XLEN +: XLEN]   = e.rec.rs1_rdata;
      bus.out_rs2_rdata[i*XLEN +: XLEN]   = e.rec.rs2_rdata;
      bus.out_rd_addr[i*5 +: 5]           = e.rec.rd_addr;
      bus.out_rd_wdata[i*XLEN +: XLEN]    = e.rec.rd_wdata;
      bus.out_mem_addr[i*XLEN +: XLEN]    = e.rec.mem_addr;
      bus.out_mem_wmask[i*4 +: 4]         = e.rec.mem_wmask;
      bus.out_mem_rdata[i*XLEN +: XLEN]   = e.rec.mem_rdata;
      bus.out_mem_wdata[i*XLEN +: XLEN]   = e.rec.mem_wdata;
    end
  end

endmodule

// File: tb/tb_rvfi_retire_queue.sv
// Testbench for rvfi_retire_queue: directed pushes feed a scoreboard, a negedge
// monitor pops and compares every record the consumer takes.
// Ports: none (top-level bench).
module tb_rvfi_retire_queue;
  import rvfi_retire_queue_pkg::*;

  localparam int DEPTH   = 8;
  localparam int NRET    = 2;
  localparam int ORDER_W = 64;

  typedef struct {
    logic [ORDER_W-1:0] order;
    rvfi_rec_t          rec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [ORDER_W-1:0] exp_order = '0;

  rvfi_retire_queue_if #(.DEPTH(DEPTH), .NRET(NRET), .ORDER_W(ORDER_W)) bus ();

  rvfi_retire_queue #(.DEPTH(DEPTH), .NRET(NRET), .ORDER_W(ORDER_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rvfi_rec_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                   input logic [31:0] wd);
    rvfi_rec_t r;
    r.insn      = {pc[15:0], 16'h0013};
    r.pc_rdata  = pc;
    r.pc_wdata  = pc + 32'd4;
    r.rs1_addr  = 5'd1;
    r.rs2_addr  = 5'd2;
    r.rs1_rdata = pc ^ 32'h1111;
    r.rs2_rdata = pc ^ 32'h2222;
    r.rd_addr   = rd;
    r.rd_wdata  = wd;
    r.mem_addr  = pc + 32'h1000;
    r.mem_wmask = 4'hf;
    r.mem_rdata = ~pc;
    r.mem_wdata = pc * 3;
    return r;
  endfunction

  task automatic drive(input rvfi_rec_t r);
    bus.in_insn      = r.insn;
    bus.in_pc_rdata  = r.pc_rdata;
    bus.in_pc_wdata  = r.pc_wdata;
    bus.in_rs1_addr  = r.rs1_addr;
    bus.in_rs2_addr  = r.rs2_addr;
    bus.in_rs1_rdata = r.rs1_rdata;
    bus.in_rs2_rdata = r.rs2_rdata;
    bus.in_rd_addr   = r.rd_addr;
    bus.in_rd_wdata  = r.rd_wdata;
    bus.in_mem_addr  = r.mem_addr;
    bus.in_mem_wmask = r.mem_wmask;
    bus.in_mem_rdata = r.mem_rdata;
    bus.in_mem_wdata = r.mem_wdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; the record is presented for one edge.
  task automatic push_rec(input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] wd, input bit exp_acc);
    rvfi_rec_t r;
    exp_t      e;
    r = mk(pc, rd, wd);
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_acc});
    drive(r);
    bus.in_valid = 1'b1;
    if (exp_acc) begin
      e.order = exp_order;
      e.rec   = r;
      if (rd == 5'd0) e.rec.rd_wdata = '0;
      sb.push_back(e);
      exp_order++;
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    bus.out_ready = 1'b1;
    repeat (cycles) step();
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    sb.delete();
    exp_order = '0;
  endtask

  // Monitor: every channel the consumer takes must match the oldest expected record.
  always @(negedge clk) begin
    if (rst && bus.out_ready) begin
      for (int i = 0; i < NRET; i++) begin
        if (bus.out_valid[i]) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_record: ch%0d pc %0h with empty scoreboard", i,
                     bus.out_pc_rdata[i*32 +: 32]);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_order", bus.out_order[i*ORDER_W +: ORDER_W], e.order);
            chk("out_pc_rdata", {32'd0, bus.out_pc_rdata[i*32 +: 32]}, {32'd0, e.rec.pc_rdata});
            chk("out_insn", {32'd0, bus.out_insn[i*32 +: 32]}, {32'd0, e.rec.insn});
            chk("out_rd_wdata", {32'd0, bus.out_rd_wdata[i*32 +: 32]}, {32'd0, e.rec.rd_wdata});
            chk("out_mem_wdata", {32'd0, bus.out_mem_wdata[i*32 +: 32]}, {32'd0, e.rec.mem_wdata});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(mk(32'h0, 5'd0, 32'h0));
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk("reset_count", {59'd0, bus.count}, 64'd0);
    chk("reset_out_valid", {62'd0, bus.out_valid}, 64'd0);
    chk("reset_overflow", {63'd0, bus.overflow}, 64'd0);

    // Reset mid-burst with in_valid high during the reset cycle.
    for (int k = 0; k < 5; k++) push_rec(32'h40 + 32'(k * 4), 5'd3, 32'h55, 1'b1);
    chk("t1_count_before", {59'd0, bus.count}, 64'd5);
    drive(mk(32'h99, 5'd3, 32'h1));
    bus.in_valid = 1'b1;
    do_reset();
    bus.in_valid = 1'b0;
    chk("t1_count", {59'd0, bus.count}, 64'd0);
    chk("t1_out_valid", {62'd0, bus.out_valid}, 64'd0);
    chk("t1_overflow", {63'd0, bus.overflow}, 64'd0);
    chk("t1_zero_pc", bus.out_pc_rdata, 64'd0);
    chk("t1_zero_order", bus.out_order[63:0], 64'd0);

    // Single push, held under backpressure; stamped order 0 after reset.
    push_rec(32'h100, 5'd4, 32'h7, 1'b1);
    chk("t2_out_valid", {62'd0, bus.out_valid}, 64'd1);
    chk("t2_pc", {32'd0, bus.out_pc_rdata[31:0]}, 64'h100);
    chk("t2_order", bus.out_order[63:0], 64'd0);
    step();
    step();
    chk("t2_hold_valid", {62'd0, bus.out_valid}, 64'd1);
    drain(1);
    chk("t2_count", {59'd0, bus.count}, 64'd0);

    // Burst drain: pairs {0,4} {8,C} then {10}.
    do_reset();
    for (int k = 0; k < 5; k++) push_rec(32'(k * 4), 5'd6, 32'(k), 1'b1);
    chk("t3_count", {59'd0, bus.count}, 64'd5);
    bus.out_ready = 1'b1;
    chk("t3_valid0", {62'd0, bus.out_valid}, 64'd3);
    chk("t3_ch1_pc", {32'd0, bus.out_pc_rdata[63:32]}, 64'h4);
    step();
    chk("t3_valid1", {62'd0, bus.out_valid}, 64'd3);
    step();
    chk("t3_valid2", {62'd0, bus.out_valid}, 64'd1);
    chk("t3_ch1_zero", {32'd0, bus.out_pc_rdata[63:32]}, 64'd0);
    step();
    chk("t3_valid3", {62'd0, bus.out_valid}, 64'd0);
    bus.out_ready = 1'b0;

    // Overflow: the ninth record is refused and does not consume an order number.
    do_reset();
    for (int k = 0; k < 8; k++) push_rec(32'h200 + 32'(k * 4), 5'd7, 32'(k), 1'b1);
    push_rec(32'h2ff, 5'd7, 32'h9, 1'b0);
    chk("t4_overflow", {63'd0, bus.overflow}, 64'd1);
    chk("t4_count_full", {59'd0, bus.count}, 64'd8);
    drain(1);
    chk("t4_count_after_pop", {59'd0, bus.count}, 64'd6);
    push_rec(32'h300, 5'd7, 32'h8, 1'b1);
    drain(4);
    chk("t4_count_empty", {59'd0, bus.count}, 64'd0);
    chk("t4_overflow_sticky", {63'd0, bus.overflow}, 64'd1);

    // Wrap: head at 7 with two entries, then pop both while pushing one.
    do_reset();
    for (int k = 0; k < 7; k++) push_rec(32'h380 + 32'(k * 4), 5'd8, 32'(k), 1'b1);
    drain(4);
    push_rec(32'h400, 5'd9, 32'h1, 1'b1);
    push_rec(32'h404, 5'd9, 32'h2, 1'b1);
    chk("t5_count2", {59'd0, bus.count}, 64'd2);
    chk("t5_ch0_pc", {32'd0, bus.out_pc_rdata[31:0]}, 64'h400);
    chk("t5_ch1_pc", {32'd0, bus.out_pc_rdata[63:32]}, 64'h404);
    bus.out_ready = 1'b1;
    push_rec(32'h408, 5'd9, 32'h3, 1'b1);
    bus.out_ready = 1'b0;
    chk("t5_count1", {59'd0, bus.count}, 64'd1);
    chk("t5_valid", {62'd0, bus.out_valid}, 64'd1);
    chk("t5_new_order", bus.out_order[63:0], 64'd9);
    drain(1);

    // x0 rule, with a non-zero rd alongside for contrast.
    push_rec(32'h500, 5'd0, 32'hDEADBEEF, 1'b1);
    push_rec(32'h504, 5'd5, 32'hDEADBEEF, 1'b1);
    chk("t6_x0_wdata", {32'd0, bus.out_rd_wdata[31:0]}, 64'd0);
    chk("t6_x5_wdata", {32'd0, bus.out_rd_wdata[63:32]}, 64'hDEADBEEF);
    drain(2);

    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
